// File: rtl/btn_debounce_if.sv
// Button bundle between the raw pin side and the debounced consumers.
interface btn_debounce_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_pin_i;
    logic [N_BTN-1:0] btn_level_o;
    logic [N_BTN-1:0] btn_press_o;
    logic [N_BTN-1:0] btn_release_o;

    modport master (
        output btn_pin_i,
        input  btn_level_o,
        input  btn_press_o,
        input  btn_release_o
    );

    modport slave (
        input  btn_pin_i,
        output btn_level_o,
        output btn_press_o,
        output btn_release_o
    );
endinterface

// File: rtl/btn_debounce.sv
// Per-button 2-FF synchronizer followed by a counter-based debounce FSM that
// produces a stable level plus one-cycle press/release strobes.
module btn_debounce #(
    parameter int N_BTN           = 4,
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic           clk,
    input  logic           rst,
    btn_debounce_if.slave  bus
);
    typedef enum logic [1:0] {IDLE_LO, CHK_HI, IDLE_HI, CHK_LO} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] r_level;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;
    state_t           r_state [N_BTN];
    logic [CNT_W-1:0] r_cnt   [N_BTN];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.btn_pin_i;
            r_sync2 <= r_sync1;
        end
    end

    // The IDLE states count the first differing sample as sample 1, so with a
    // single-cycle debounce they accept immediately and skip the CHK states.
    always_ff @(posedge clk) begin
        for (int b = 0; b < N_BTN; b++) begin
            if (rst) begin
                r_state[b]   <= IDLE_LO;
                r_cnt[b]     <= '0;
                r_level[b]   <= 1'b0;
                r_press[b]   <= 1'b0;
                r_release[b] <= 1'b0;
            end else begin
                r_press[b]   <= 1'b0;
                r_release[b] <= 1'b0;
                case (r_state[b])
                    IDLE_LO: begin
                        if (r_sync2[b]) begin
                            if (SINGLE) begin
                                r_state[b] <= IDLE_HI;
                                r_level[b] <= 1'b1;
                                r_press[b] <= 1'b1;
                                r_cnt[b]   <= '0;
                            end else begin
                                r_state[b] <= CHK_HI;
                                r_cnt[b]   <= CNT_ONE;
                            end
                        end else begin
                            r_cnt[b] <= '0;
                        end
                    end
                    CHK_HI: begin
                        if (!r_sync2[b]) begin
                            r_state[b] <= IDLE_LO;
                            r_cnt[b]   <= '0;
                        end else if (r_cnt[b] == CNT_LAST) begin
                            r_state[b] <= IDLE_HI;
                            r_level[b] <= 1'b1;
                            r_press[b] <= 1'b1;
                            r_cnt[b]   <= '0;
                        end else begin
                            r_cnt[b] <= r_cnt[b] + CNT_ONE;
                        end
                    end
                    IDLE_HI: begin
                        if (!r_sync2[b]) begin
                            if (SINGLE) begin
                                r_state[b]   <= IDLE_LO;
                                r_level[b]   <= 1'b0;
                                r_release[b] <= 1'b1;
                                r_cnt[b]     <= '0;
                            end else begin
                                r_state[b] <= CHK_LO;
                                r_cnt[b]   <= CNT_ONE;
                            end
                        end else begin
                            r_cnt[b] <= '0;
                        end
                    end
                    CHK_LO: begin
                        if (r_sync2[b]) begin
                            r_state[b] <= IDLE_HI;
                            r_cnt[b]   <= '0;
                        end else if (r_cnt[b] == CNT_LAST) begin
                            r_state[b]   <= IDLE_LO;
                            r_level[b]   <= 1'b0;
                            r_release[b] <= 1'b1;
                            r_cnt[b]     <= '0;
                        end else begin
                            r_cnt[b] <= r_cnt[b] + CNT_ONE;
                        end
                    end
                    default: begin
                        r_state[b] <= IDLE_LO;
                        r_cnt[b]   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.btn_level_o   = r_level;
    assign bus.btn_press_o   = r_press;
    assign bus.btn_release_o = r_release;
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed scenarios plus random pin activity, all
// compared against a sliding-window reference model of the debounce rules.
module tb_btn_debounce;
    localparam int N_BTN = 4;
    localparam int CNT_W = 4;
    localparam int D     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    btn_debounce_if #(.N_BTN(N_BTN)) bif ();

    btn_debounce #(
        .N_BTN(N_BTN), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the FSM input is the pin seen two edges earlier; the
    // level flips once the last D FSM inputs all differ from the current level.
    logic [N_BTN-1:0] cap_pin;
    logic             cap_rst;
    bit               cap_vld = 1'b0;
    logic [N_BTN-1:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_press = '0, m_rel = '0;
    bit               win [N_BTN][$];

    always @(posedge clk) begin
        cap_pin = bif.btn_pin_i;
        cap_rst = rst;
        cap_vld = 1'b1;
    end

    always @(negedge clk) begin
        if (cap_vld) begin
            if (cap_rst) begin
                m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
                for (int b = 0; b < N_BTN; b++) win[b].delete();
            end else begin
                m_press = '0;
                m_rel   = '0;
                for (int b = 0; b < N_BTN; b++) begin
                    bit all_diff;
                    win[b].push_back(m_s2[b]);
                    if (win[b].size() > D) void'(win[b].pop_front());
                    if (win[b].size() == D) begin
                        all_diff = 1'b1;
                        for (int i = 0; i < D; i++)
                            if (win[b][i] == m_level[b]) all_diff = 1'b0;
                        if (all_diff) begin
                            m_level[b] = ~m_level[b];
                            if (m_level[b]) m_press[b] = 1'b1;
                            else            m_rel[b]   = 1'b1;
                        end
                    end
                end
                m_s2 = m_s1;
                m_s1 = cap_pin;
            end
            chk("level",   32'(bif.btn_level_o),   32'(m_level));
            chk("press",   32'(bif.btn_press_o),   32'(m_press));
            chk("release", 32'(bif.btn_release_o), 32'(m_rel));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int hold [N_BTN];
        bif.btn_pin_i = '0;
        rst = 1'b1;
        tick(2);
        chk("reset_level", 32'(bif.btn_level_o), 32'h0);
        chk("reset_press", 32'(bif.btn_press_o), 32'h0);
        rst = 1'b0;
        tick(3);

        // 1. clean press on bit 0
        bif.btn_pin_i[0] = 1'b1;
        tick(9);
        chk("t1_level_before", 32'(bif.btn_level_o[0]), 32'h0);
        tick();
        chk("t1_level", 32'(bif.btn_level_o[0]), 32'h1);
        chk("t1_press", 32'(bif.btn_press_o[0]), 32'h1);
        tick();
        chk("t1_press_1cyc", 32'(bif.btn_press_o[0]), 32'h0);

        // 2. bounce on bit 2, then hold
        for (int i = 0; i < 4; i++) begin
            bif.btn_pin_i[2] = (i % 2 == 0);
            tick(3);
        end
        bif.btn_pin_i[2] = 1'b1;
        tick(9);
        chk("t2_level_before", 32'(bif.btn_level_o[2]), 32'h0);
        tick();
        chk("t2_press", 32'(bif.btn_press_o[2]), 32'h1);

        // 3. release on bit 1
        bif.btn_pin_i[1] = 1'b1;
        tick(12);
        chk("t3_level_hi", 32'(bif.btn_level_o[1]), 32'h1);
        bif.btn_pin_i[1] = 1'b0;
        tick(10);
        chk("t3_release", 32'(bif.btn_release_o[1]), 32'h1);
        chk("t3_level_lo", 32'(bif.btn_level_o[1]), 32'h0);
        tick();
        chk("t3_release_1cyc", 32'(bif.btn_release_o[1]), 32'h0);

        // 4. short glitch low on bit 3 while held
        bif.btn_pin_i[3] = 1'b1;
        tick(12);
        bif.btn_pin_i[3] = 1'b0;
        tick(5);
        bif.btn_pin_i[3] = 1'b1;
        tick(15);
        chk("t4_level_kept", 32'(bif.btn_level_o[3]), 32'h1);

        // 5. all buttons pressed on the same edge
        bif.btn_pin_i = '0;
        tick(12);
        bif.btn_pin_i = '1;
        tick(10);
        chk("t5_press_all", 32'(bif.btn_press_o), 32'hF);
        chk("t5_release_none", 32'(bif.btn_release_o), 32'h0);

        // 6. reset mid-count with bit 0 held high
        bif.btn_pin_i = '0;
        tick(12);
        bif.btn_pin_i[0] = 1'b1;
        tick(6);
        rst = 1'b1;
        tick();
        chk("t6_reset_out", 32'(bif.btn_level_o), 32'h0);
        rst = 1'b0;
        tick(9);
        chk("t6_press_before", 32'(bif.btn_press_o[0]), 32'h0);
        tick();
        chk("t6_press", 32'(bif.btn_press_o[0]), 32'h1);

        // random pin activity with occasional resets
        for (int b = 0; b < N_BTN; b++) hold[b] = $urandom_range(1, 14);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N_BTN; b++) begin
                hold[b]--;
                if (hold[b] <= 0) begin
                    bif.btn_pin_i[b] = ~bif.btn_pin_i[b];
                    hold[b] = $urandom_range(1, 14);
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
            chk("no_both_strobes", 32'(bif.btn_press_o & bif.btn_release_o), 32'h0);
        end
        rst = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
